// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter: direction encoding and Gray encoder.
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Width-generic Gray encoder; callers truncate the result to their own width.
  function automatic logic [31:0] gray_enc(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Clock-enable prescaler: emits a one-cycle step every PRESCALE enabled cycles.
module clk_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  // PRESCALE=1 keeps a 1-bit counter pinned at 0, so step degenerates to en.
  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == Last) begin
        step  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo counter with load, clear, wrap/saturate, prescaler,
// terminal-count pulse, sticky overflow and registered Gray output.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             boundary;

  clk_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .sync_clr(clr | load),
    .step    (step)
  );

  // Next-count with clr > load > step priority.
  always_comb begin
    count_d  = count_q;
    boundary = 1'b0;
    if (clr) begin
      count_d = RstVal;
    end else if (load) begin
      count_d = load_val;
    end else if (step) begin
      if (up_dn == CNT_UP) begin
        if (count_q < max_val) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          boundary = 1'b1;
          count_d  = sat_mode ? max_val : '0;
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          count_d  = sat_mode ? '0 : max_val;
        end else if (count_q > max_val) begin
          // Out-of-range loaded value snaps back into range without flagging.
          count_d = max_val;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    tc_d   = boundary;
    ovf_d  = clr ? 1'b0 : (ovf_q | boundary);
    gray_d = WIDTH'(gray_enc(32'(count_d)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= RstVal;
      gray_q  <= WIDTH'(gray_enc(32'(RstVal)));
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= gray_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign count_gray = gray_q;
  assign tc         = tc_q;
  assign ovf        = ovf_q;

endmodule
